// File: rtl/rotary_encoder_gen.sv
// Quadrature pattern generator for a two-contact rotary encoder: one full Gray
// cycle (detent) per accepted step, with optional contact chatter after each edge.
module rotary_encoder_gen #(
  parameter int unsigned PHASE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned BOUNCE       = 0
) (
  input  logic CLK_i,
  input  logic RST_i,
  input  logic step_valid_i,
  input  logic step_dir_i,
  output logic step_ready_o,
  output logic rot_1_o,
  output logic rot_2_o,
  output logic busy_o,
  output logic step_done_o
);

  localparam int unsigned MAX_CYC = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam int unsigned BW1     = 2 * BOUNCE + 1;
  localparam logic [CW-1:0] P_LAST = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_Q1,
    S_Q2,
    S_Q3,
    S_Q4,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [1:0]    rot_q, rot_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] k;
  logic [1:0]    pat_new, pat_old;
  logic          chatter;

  // Steady {rot_1,rot_2} level for a quarter state and direction.
  function automatic logic [1:0] pattern(input state_e s, input logic dir);
    case (s)
      S_Q1:    pattern = dir ? 2'b10 : 2'b01;
      S_Q2:    pattern = 2'b11;
      S_Q3:    pattern = dir ? 2'b01 : 2'b10;
      default: pattern = 2'b00;
    endcase
  endfunction

  // Quarter that precedes a given quarter (Q1 follows rest).
  function automatic state_e prev_quarter(input state_e s);
    case (s)
      S_Q2:    prev_quarter = S_Q1;
      S_Q3:    prev_quarter = S_Q2;
      S_Q4:    prev_quarter = S_Q3;
      default: prev_quarter = S_IDLE;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (step_valid_i) begin
          state_d = S_Q1;
          cnt_d   = P_LAST;
          dir_d   = step_dir_i;
        end
      end
      S_Q1, S_Q2, S_Q3: begin
        if (cnt_q == '0) begin
          state_d = (state_q == S_Q1) ? S_Q2 : (state_q == S_Q2) ? S_Q3 : S_Q4;
          cnt_d   = P_LAST;
          done_d  = (state_q == S_Q3);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_Q4: begin
        if (cnt_q == '0) begin
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          cnt_d   = G_LAST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Chatter: the line that changed on quarter entry shows its old level on odd k inside the window.
    k       = P_LAST - cnt_d;
    pat_new = pattern(state_d, dir_d);
    pat_old = pattern(prev_quarter(state_d), dir_d);
    chatter = (state_d inside {S_Q1, S_Q2, S_Q3, S_Q4}) && k[0] && ((32'(k) + 32'd1) < BW1);
    rot_d   = pat_new ^ ((pat_new ^ pat_old) & {2{chatter}});
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 2'b00;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign step_ready_o = ready_q;
  assign busy_o       = busy_q;
  assign step_done_o  = done_q;
  assign rot_1_o      = rot_q[1];
  assign rot_2_o      = rot_q[0];

endmodule
